// File: rtl/residue_pkg.sv
// residue_pkg: shared types and helpers for the round-robin mod-7 residue scheduler.
//   sched_state_t : scheduler FSM states
//   RES_MOD/RES_W : modulus and residue width
//   W0/W1/W2      : weight rotor values (2^k mod 7 cycles 1,2,4)
//   mod7_add      : (a+b) mod 7 for a, b in 0..7
package residue_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} sched_state_t;

    localparam int RES_MOD = 7;
    localparam int RES_W   = 3;

    localparam logic [RES_W-1:0] W0 = 3'd1;
    localparam logic [RES_W-1:0] W1 = 3'd2;
    localparam logic [RES_W-1:0] W2 = 3'd4;

    // Sum is at most 14, so at most two subtractions of the modulus are needed.
    function automatic logic [RES_W-1:0] mod7_add(input logic [RES_W-1:0] a,
                                                  input logic [RES_W-1:0] b);
        logic [RES_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 4'(2 * RES_MOD))
            s = s - 4'(2 * RES_MOD);
        else if (s >= 4'(RES_MOD))
            s = s - 4'(RES_MOD);
        return s[RES_W-1:0];
    endfunction

endpackage

// File: rtl/residue_acc.sv
// residue_acc: serial mod-7 residue engine, one bit per enabled cycle, LSB first.
//   clk, rst_n : clock, async active-low reset
//   clr        : restart engine (acc = 0, weight = 1); wins over en
//   en         : consume bit_in this cycle
//   bit_in     : serial input bit
//   residue    : running residue, always 0..6
module residue_acc
    import residue_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [RES_W-1:0] residue
);

    logic [RES_W-1:0] weight;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            residue <= '0;
            weight  <= W0;
        end else if (clr) begin
            residue <= '0;
            weight  <= W0;
        end else if (en) begin
            if (bit_in)
                residue <= mod7_add(residue, weight);
            // 2^k mod 7 repeats with period 3, so a one-hot rotate gives 1,2,4,1,...
            weight <= {weight[RES_W-2:0], weight[RES_W-1]};
        end
    end

endmodule

// File: rtl/residue_sched.sv
// residue_sched: round-robin scheduler sharing one serial mod-7 engine among
// NUM_REQ requesters.
//   clk, rst_n : clock, async active-low reset
//   req_valid  : per-requester word valid
//   req_data   : packed words, requester i at [i*WIDTH +: WIDTH]
//   req_ready  : one-hot accept strobe (combinational, IDLE only)
//   flush      : synchronous abort; drops any in-flight result
//   res_valid, res_ready, res_data, res_id : result handshake
//   busy       : high whenever the FSM is not IDLE
module residue_sched
    import residue_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     flush,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [RES_W-1:0]         res_data,
    output logic [ID_W-1:0]          res_id,
    output logic                     busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    // Weight applied to the final bit is fixed by WIDTH, so the result can be
    // folded in the last SHIFT cycle without waiting for the engine register.
    localparam logic [RES_W-1:0] LAST_W = ((WIDTH - 1) % 3 == 0) ? W0 :
                                          ((WIDTH - 1) % 3 == 1) ? W1 : W2;

    sched_state_t                  state;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_words;
    logic [WIDTH-1:0]              shreg;
    logic [CNT_W-1:0]              cnt;
    logic [ID_W-1:0]               ptr;
    logic [ID_W-1:0]               cur_id;
    logic [ID_W-1:0]               grant;
    logic                          grant_vld;
    logic                          accept;
    logic                          eng_en;
    logic [RES_W-1:0]              residue;
    logic [RES_W-1:0]              final_res;

    assign req_words = req_data;

    // Round-robin search: first valid index upward from ptr+1, with wrap.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant     = ID_W'(idx);
            end
        end
    end

    // Gated by rst_n so req_ready reads 0 while reset is held.
    assign accept = rst_n && (state == IDLE) && !flush && grant_vld;

    always_comb begin
        req_ready = '0;
        if (accept)
            req_ready[grant] = 1'b1;
    end

    assign eng_en    = (state == SHIFT);
    assign final_res = shreg[0] ? mod7_add(residue, LAST_W) : residue;

    residue_acc u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .en      (eng_en),
        .bit_in  (shreg[0]),
        .residue (residue)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= ID_W'(NUM_REQ - 1);
            cur_id    <= '0;
            shreg     <= '0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg  <= req_words[grant];
                        cur_id <= grant;
                        ptr    <= grant;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        shreg <= shreg >> 1;
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            res_valid <= 1'b1;
                            res_data  <= final_res;
                            res_id    <= cur_id;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    // flush and a handshake both leave; flush just means the
                    // consumer's res_ready is ignored and the result is lost.
                    if (flush || res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_residue_sched.sv
// tb_residue_sched: randomized self-checking bench for residue_sched.
// Expected residues come from word % 7; grant order from "next valid index
// after the last grant" arithmetic.
module tb_residue_sched;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 16;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     flush;
    logic                     res_valid;
    logic                     res_ready;
    logic [2:0]               res_data;
    logic [ID_W-1:0]          res_id;
    logic                     busy;

    int n_vec = 0;
    int n_err = 0;

    residue_sched #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .flush     (flush),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] ref_res(input logic [WIDTH-1:0] w);
        return 3'(int'(w) % 7);
    endfunction

    // Ticks until res_valid; returns number of ticks, or -1 on timeout.
    task automatic wait_res(output int lat);
        lat = 0;
        while (res_valid !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        if (res_valid !== 1'b1) lat = -1;
    endtask

    // Offers one word on requester r alone, returns the accept strobe, the
    // result and accept-to-res_valid latency, and completes the handshake.
    task automatic send_one(input int r, input logic [WIDTH-1:0] w,
                            output logic [NUM_REQ-1:0] rdy, output logic [2:0] d,
                            output logic [ID_W-1:0] id, output int lat);
        int l;
        res_ready = 1'b1;
        req_data[r*WIDTH +: WIDTH] = w;
        req_valid = '0;
        req_valid[r] = 1'b1;
        #1;
        rdy = req_ready;
        tick();
        req_valid = '0;
        wait_res(l);
        lat = (l < 0) ? -1 : l + 1;
        d  = res_data;
        id = res_id;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '1;
        tick();
        tick();
        n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        n_vec++; if (res_data !== 3'd0) begin n_err++; $display("FAIL reset_res_data: got %0d want 0", res_data); end
        n_vec++; if (res_id !== '0) begin n_err++; $display("FAIL reset_res_id: got %0d want 0", res_id); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        req_valid = '0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_word_value();
        logic [NUM_REQ-1:0] rdy;
        logic [2:0] d;
        logic [ID_W-1:0] id;
        int lat;
        send_one(0, 16'd100, rdy, d, id, lat);
        n_vec++; if (rdy !== 4'b0001) begin n_err++; $display("FAIL word100_ready: got %b want 0001", rdy); end
        n_vec++; if (lat != WIDTH + 1) begin n_err++; $display("FAIL word100_latency: got %0d want %0d", lat, WIDTH + 1); end
        n_vec++; if (d !== 3'd2) begin n_err++; $display("FAIL word100_data: got %0d want 2", d); end
        n_vec++; if (id !== 2'd0) begin n_err++; $display("FAIL word100_id: got %0d want 0", id); end
    endtask

    task automatic test_edge_values();
        logic [WIDTH-1:0] words [4];
        logic [2:0] exp_d [4];
        logic [NUM_REQ-1:0] rdy;
        logic [2:0] d;
        logic [ID_W-1:0] id;
        int lat, r;
        words = '{16'hFFFF, 16'd0, 16'd49, 16'd13};
        exp_d = '{3'd1, 3'd0, 3'd0, 3'd6};
        for (int i = 0; i < 4; i++) begin
            r = $urandom_range(NUM_REQ - 1);
            send_one(r, words[i], rdy, d, id, lat);
            n_vec++; if (d !== exp_d[i]) begin n_err++; $display("FAIL edge_data[%0h]: got %0d want %0d", words[i], d, exp_d[i]); end
            n_vec++; if (id !== ID_W'(r)) begin n_err++; $display("FAIL edge_id[%0h]: got %0d want %0d", words[i], id, r); end
        end
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] rdy;
        logic [WIDTH-1:0] w;
        logic [2:0] d;
        logic [ID_W-1:0] id;
        int lat, r;
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(NUM_REQ - 1);
            w = WIDTH'($urandom);
            send_one(r, w, rdy, d, id, lat);
            n_vec++;
            if (d !== ref_res(w) || id !== ID_W'(r) || lat != WIDTH + 1) begin
                n_err++;
                $display("FAIL random[%0d]: word %0h req %0d got res %0d id %0d lat %0d want res %0d id %0d lat %0d",
                         i, w, r, d, id, lat, ref_res(w), r, WIDTH + 1);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [WIDTH-1:0] words [NUM_REQ];
        logic [NUM_REQ-1:0] expv;
        int gq[$];
        int exp_ptr, exp_g, n_acc, n_res, last_cyc;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        exp_ptr = NUM_REQ - 1;
        n_acc = 0;
        n_res = 0;
        last_cyc = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            words[i] = WIDTH'($urandom);
            req_data[i*WIDTH +: WIDTH] = words[i];
        end
        res_ready = 1'b1;
        req_valid = '1;
        #1;
        for (int cyc = 0; cyc < 400 && n_res < 5; cyc++) begin
            if (req_ready !== '0 && n_acc < 5) begin
                exp_g = (exp_ptr + 1) % NUM_REQ;
                expv = '0;
                expv[exp_g] = 1'b1;
                n_vec++; if (req_ready !== expv) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", n_acc, req_ready, expv); end
                if (n_acc > 0) begin
                    n_vec++; if (cyc - last_cyc != WIDTH + 2) begin n_err++; $display("FAIL rr_period[%0d]: got %0d want %0d", n_acc, cyc - last_cyc, WIDTH + 2); end
                end
                last_cyc = cyc;
                gq.push_back(exp_g);
                exp_ptr = exp_g;
                n_acc++;
            end
            if (res_valid === 1'b1 && gq.size() > 0) begin
                n_vec++;
                if (res_id !== ID_W'(gq[0]) || res_data !== ref_res(words[gq[0]])) begin
                    n_err++;
                    $display("FAIL rr_result[%0d]: got id %0d res %0d want id %0d res %0d",
                             n_res, res_id, res_data, gq[0], ref_res(words[gq[0]]));
                end
                void'(gq.pop_front());
                n_res++;
            end
            tick();
            if (n_acc == 5) req_valid = '0;
        end
        req_valid = '0;
        n_vec++; if (n_res != 5) begin n_err++; $display("FAIL rr_count: got %0d results want 5", n_res); end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] w1, w2;
        int l;
        w1 = WIDTH'($urandom);
        w2 = WIDTH'($urandom);
        res_ready = 1'b0;
        req_data[1*WIDTH +: WIDTH] = w1;
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        wait_res(l);
        n_vec++; if (l != WIDTH || res_data !== ref_res(w1) || res_id !== 2'd1) begin
            n_err++; $display("FAIL bp_first: got lat %0d res %0d id %0d want lat %0d res %0d id 1", l, res_data, res_id, WIDTH, ref_res(w1));
        end
        req_data[2*WIDTH +: WIDTH] = w2;
        req_valid = 4'b0100;
        #1;
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (res_valid !== 1'b1 || res_data !== ref_res(w1) || res_id !== 2'd1 || req_ready !== '0) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got v %b res %0d id %0d rdy %b want v 1 res %0d id 1 rdy 0000",
                         i, res_valid, res_data, res_id, req_ready, ref_res(w1));
            end
            tick();
        end
        res_ready = 1'b1;
        tick();
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", res_valid); end
        n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_next_accept: got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        wait_res(l);
        n_vec++; if (res_data !== ref_res(w2) || res_id !== 2'd2) begin
            n_err++; $display("FAIL bp_second: got res %0d id %0d want res %0d id 2", res_data, res_id, ref_res(w2));
        end
        tick();
    endtask

    task automatic test_flush();
        logic [NUM_REQ-1:0] rdy;
        logic [WIDTH-1:0] w, w2;
        logic [2:0] d;
        logic [ID_W-1:0] id;
        int lat;
        bit seen;
        flush = 1'b1;
        req_valid = 4'b1000;
        #1;
        n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL flush_idle_ready: got %b want 0000", req_ready); end
        tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_idle_busy: got %b want 0", busy); end
        flush = 1'b0;
        req_valid = '0;
        w = WIDTH'($urandom);
        req_data[0 +: WIDTH] = w;
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        repeat (5) tick();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_shift_busy: got %b want 1", busy); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_vec++; if (busy !== 1'b0 || res_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_shift_abort: got busy %b v %b want 0 0", busy, res_valid);
        end
        seen = 1'b0;
        repeat (30) begin
            if (res_valid === 1'b1) seen = 1'b1;
            tick();
        end
        n_vec++; if (seen) begin n_err++; $display("FAIL flush_no_result: got res_valid 1 want 0"); end
        w2 = WIDTH'($urandom);
        send_one(2, w2, rdy, d, id, lat);
        n_vec++; if (d !== ref_res(w2) || id !== 2'd2 || lat != WIDTH + 1) begin
            n_err++; $display("FAIL flush_next: got res %0d id %0d lat %0d want res %0d id 2 lat %0d", d, id, lat, ref_res(w2), WIDTH + 1);
        end
    endtask

    task automatic test_flush_done();
        int l;
        res_ready = 1'b0;
        req_data[1*WIDTH +: WIDTH] = WIDTH'($urandom);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        wait_res(l);
        n_vec++; if (l != WIDTH) begin n_err++; $display("FAIL flushdone_reach: got lat %0d want %0d", l, WIDTH); end
        flush = 1'b1;
        res_ready = 1'b1;
        tick();
        flush = 1'b0;
        n_vec++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL flushdone_drop: got v %b busy %b want 0 0", res_valid, busy);
        end
        tick();
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL flushdone_after: got %b want 0", res_valid); end
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] w0;
        logic [NUM_REQ-1:0] expv;
        int l;
        req_data[2*WIDTH +: WIDTH] = WIDTH'($urandom);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || res_data !== 3'd0 || res_id !== '0 || req_ready !== '0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got busy %b v %b res %0d id %0d rdy %b want all 0",
                     busy, res_valid, res_data, res_id, req_ready);
        end
        tick();
        rst_n = 1'b1;
        w0 = WIDTH'($urandom);
        for (int i = 0; i < NUM_REQ; i++) req_data[i*WIDTH +: WIDTH] = (i == 0) ? w0 : WIDTH'($urandom);
        req_valid = '1;
        #1;
        expv = 4'b0001;
        n_vec++; if (req_ready !== expv) begin n_err++; $display("FAIL rst_mid_first_grant: got %b want %b", req_ready, expv); end
        tick();
        req_valid = '0;
        wait_res(l);
        n_vec++; if (l != WIDTH || res_id !== 2'd0 || res_data !== ref_res(w0)) begin
            n_err++; $display("FAIL rst_mid_result: got lat %0d id %0d res %0d want lat %0d id 0 res %0d", l, res_id, res_data, WIDTH, ref_res(w0));
        end
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        flush     = 1'b0;
        res_ready = 1'b1;
        test_reset();
        test_word_value();
        test_edge_values();
        test_random();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_flush_done();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/residue_sched.md
Name: residue_sched

Overview:
Round-robin scheduler that shares one serial mod-7 residue engine between NUM_REQ requesters. Each requester offers a WIDTH-bit word over a valid/ready handshake. The block arbitrates, serializes the accepted word LSB-first into the engine and restarts the engine between words. It returns the residue (word mod 7) with the originating requester ID over a backpressured result handshake.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 16, bits per word (>=1)
ID_W, $clog2(NUM_REQ), derived; width of res_id

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester word valid
req_data  in  NUM_REQ*WIDTH  packed words; requester i occupies bits [i*WIDTH +: WIDTH]
req_ready  out  NUM_REQ  one-hot accept strobe
flush  in  1  synchronous abort of the current operation
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_data  out  3  residue, 0..6
res_id  out  ID_W  index of requester that owns res_data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n low) values:
  - FSM = IDLE; req_ready = 0; res_valid = 0; res_data = 0; res_id = 0; busy = 0.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
  - Shift register, bit counter and engine accumulator = 0.
  - Reset mid-operation discards all work; no result is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If flush = 0 and any req_valid is high, grant the first valid index searching upward (with wrap) from pointer+1.
  - req_ready[grant] = 1 combinationally in that cycle; that transfer is the accept.
  - On accept: load shifter with req_data[grant]; latch grant as id; pointer <= grant; clear engine (acc = 0, weight = 1); cnt = 0; go to SHIFT.
  - No valid request, or flush = 1: all req_ready = 0; stay in IDLE.
- SHIFT:
  - Each cycle feed bit cnt of the word (LSB first) into the engine.
  - acc <= (acc + bit*weight) mod 7, computed as a 3-bit add with mod-7 fold; acc is always in 0..6, never 7.
  - weight rotates 1 -> 2 -> 4 -> 1 every cycle, regardless of the bit value.
  - After the cycle with cnt = WIDTH-1: go to DONE; res_data <= final acc; res_id <= latched id.
  - req_ready = 0 throughout.
- DONE:
  - res_valid = 1; res_data and res_id stay stable until res_ready = 1.
  - On handshake: res_valid <= 0 next cycle; go to IDLE.
  - No accept in the handshake cycle. Minimum per-word period is WIDTH+2 cycles.
- Latency: accept in cycle t gives res_valid high in cycle t+WIDTH+1 (res_ready held high).
- flush:
  - In SHIFT or DONE: return to IDLE next cycle and drop the result; res_valid falls next cycle.
  - flush has priority over a same-cycle res_ready handshake; the result counts as dropped.
  - The RR pointer keeps its last grant.
- Starvation freedom: a requester holding req_valid high is granted within NUM_REQ accepts.
- A requester deasserting req_valid before it is granted is legal.
- Granted data is sampled only in the accept cycle.

Decomposition:
- Package residue_pkg holds:
  - state enum sched_state_t {IDLE, SHIFT, DONE};
  - localparam RES_MOD = 7 and RES_W = 3;
  - weight rotor constants W0 = 1, W1 = 2, W2 = 4;
  - function mod7_add(a, b) returning (a+b) mod 7 for a, b in 0..7.
- Sub-module residue_acc: clk, rst_n, clr, en, bit_in, residue[2:0]. It contains the accumulator and the 1/2/4 weight rotor.
- residue_sched contains the arbiter, serializer, counter and FSM.

Test Plan:
- Word value: req0 word 100 -> one req_ready[0] pulse; res_valid after WIDTH+1 = 17 cycles; res_data = 2; res_id = 0.
- Edge values: 0xFFFF -> 1; 0 -> 0; 49 -> 0; 13 -> 6. Random 500 words checked against word % 7; res_data never 7.
- Round-robin: all 4 req_valid held high, res_ready tied 1 -> grant order 0,1,2,3,0; consecutive accepts exactly 18 cycles apart.
- Backpressure: res_ready low for 10 cycles in DONE -> res_data/res_id stable, req_ready all 0; release -> IDLE, next accept one cycle later.
- Flush: flush at SHIFT cycle 5 -> no res_valid for that word; next request (req2) yields a correct residue. Flush in DONE together with res_ready -> result dropped, res_valid falls.
- Reset: assert rst_n low mid-SHIFT -> all outputs return to reset values immediately; after release, requester 0 is granted first.
